// File: rtl/fmap_stream_reader.sv
// fmap_stream_reader: streams a contiguous feature-map region out of a
// single-port synchronous RAM as a valid/ready word stream.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start, base_addr, len transfer request (sampled while idle)
//   busy, done            status, done is a one-cycle completion pulse
//   mem_rd_en/addr/data   RAM read port, data returns one cycle later
//   m_valid/ready/data    output stream, m_last flags the final word
//   stall_cnt             back-pressure cycle counter, present only when
//                         FMAP_READER_STALL_CNT_EN is defined
module fmap_stream_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   len,
   output logic                  busy,
   output logic                  done,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_rd_addr,
   input  logic [DATA_WIDTH-1:0] mem_rd_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last
`ifdef FMAP_READER_STALL_CNT_EN
   ,
   output logic [15:0]           stall_cnt
`endif
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

   logic [1:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH:0]   len_q, len_d;
   logic [ADDR_WIDTH:0]   issued_q, issued_d;
   logic [ADDR_WIDTH:0]   accepted_q, accepted_d;
   logic                  infl_q, infl_d;
   logic                  infl_last_q, infl_last_d;
   logic [DATA_WIDTH-1:0] bdata_q [2];
   logic [DATA_WIDTH-1:0] bdata_d [2];
   logic                  blast_q [2];
   logic                  blast_d [2];
   logic                  wr_ptr_q, wr_ptr_d;
   logic                  rd_ptr_q, rd_ptr_d;
   logic [1:0]            count_q, count_d;

   logic                  pop;
   logic                  issue;
   logic                  issue_last;
   logic [2:0]            occ;
   logic                  credit_ok;

   always_comb begin
      pop        = (count_q != 2'd0) & m_ready;
      // Words buffered plus the one possibly returning from RAM must
      // leave room for the read issued this cycle.
      occ        = {1'b0, count_q} + {2'b00, infl_q};
      credit_ok  = occ < (3'd2 + {2'b00, pop});
      issue      = (state_q == S_READ) & credit_ok;
      issue_last = (issued_q + ONE) == len_q;

      state_d     = state_q;
      addr_d      = addr_q;
      len_d       = len_q;
      issued_d    = issued_q;
      accepted_d  = accepted_q;
      infl_d      = issue;
      infl_last_d = issue & issue_last;
      bdata_d     = bdata_q;
      blast_d     = blast_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q + {1'b0, infl_q} - {1'b0, pop};

      if (infl_q) begin
         bdata_d[wr_ptr_q] = mem_rd_data;
         blast_d[wr_ptr_q] = infl_last_q;
         wr_ptr_d          = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d   = ~rd_ptr_q;
         accepted_d = accepted_q + ONE;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d     = base_addr;
               len_d      = len;
               issued_d   = '0;
               accepted_d = '0;
               state_d    = (len == '0) ? S_DONE : S_READ;
            end
         end
         S_READ: begin
            if (issue) begin
               addr_d   = addr_q + 1'b1;
               issued_d = issued_q + ONE;
               if (issue_last) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (pop && ((accepted_q + ONE) == len_q)) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         len_q       <= '0;
         issued_q    <= '0;
         accepted_q  <= '0;
         infl_q      <= 1'b0;
         infl_last_q <= 1'b0;
         bdata_q[0]  <= '0;
         bdata_q[1]  <= '0;
         blast_q[0]  <= 1'b0;
         blast_q[1]  <= 1'b0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         count_q     <= 2'd0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         issued_q    <= issued_d;
         accepted_q  <= accepted_d;
         infl_q      <= infl_d;
         infl_last_q <= infl_last_d;
         bdata_q     <= bdata_d;
         blast_q     <= blast_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
      end
   end

   assign busy        = state_q != S_IDLE;
   assign done        = state_q == S_DONE;
   assign mem_rd_en   = issue;
   assign mem_rd_addr = addr_q;
   assign m_valid     = count_q != 2'd0;
   assign m_data      = bdata_q[rd_ptr_q];
   assign m_last      = blast_q[rd_ptr_q];

`ifdef FMAP_READER_STALL_CNT_EN
   logic [15:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if ((state_q == S_IDLE) && start) begin
         stall_d = '0;
      end else if (m_valid && !m_ready && (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) stall_q <= '0;
      else        stall_q <= stall_d;
   end

   assign stall_cnt = stall_q;
`endif

endmodule
